// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit owning the HI/LO register
//                pair. Runs mult/multu (shift-add, LSB first) and div/divu
//                (restoring, MSB first) in WIDTH iterations plus one
//                sign-correction cycle, and services mthi/mtlo in IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_q;      // product / quotient sign
    logic               r_neg_r;      // remainder sign
    logic               r_dz;         // divide by zero seen at launch
    logic [WIDTH-1:0]   r_a_orig;     // raw dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]   r_opnd;       // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;        // mult: {partial product, multiplier}; div: low half = dividend/quotient
    logic [WIDTH-1:0]   r_rem;        // settled partial remainder (always < divisor)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    // Launch-time operand conditioning: magnitudes and sign flags.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? (~a + 1'b1) : a;
    assign w_mag_b  = w_b_neg ? (~b + 1'b1) : b;

    // One shift-add step: add the multiplicand if the current multiplier bit is set.
    logic [WIDTH:0] w_msum;
    assign w_msum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // One restoring-division step on the WIDTH+1-bit partial remainder.
    logic [WIDTH:0] w_dshift;
    logic [WIDTH:0] w_ddiff;
    assign w_dshift = {r_rem, r_acc[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_opnd};

    // Sign-corrected results presented in FINISH.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // Sequencer and iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_a_orig <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state  <= c_st_run;
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dz     <= (b == '0);
                        r_a_orig <= a;
                        r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_rem    <= '0;
                    end
                end
                c_st_run: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_finish;
                    end
                    if (r_is_div) begin
                        // Borrow out of the subtract means the divisor did not fit: restore.
                        r_rem               <= w_ddiff[WIDTH] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
                        r_acc[WIDTH-1:0]    <= {r_acc[WIDTH-2:0], ~w_ddiff[WIDTH]};
                    end else begin
                        r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                    end
                end
                c_st_finish: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // HI/LO ownership plus registered busy/done status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_st_finish);
            r_busy <= ((r_state == c_st_idle) & start) | (r_state == c_st_run);
            if (r_state == c_st_finish) begin
                if (r_is_div) begin
                    if (r_dz) begin
                        r_lo <= '1;
                        r_hi <= r_a_orig;
                    end else begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end
                end else begin
                    r_hi <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod[WIDTH-1:0];
                end
            end else if (r_state == c_st_idle) begin
                if (wr_hi) begin
                    r_hi <= wr_data;
                end
                if (wr_lo) begin
                    r_lo <= wr_data;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Scoreboard bench for muldiv_unit. The driver pushes the
//                reference {HI,LO} for every launched operation; a monitor
//                pops and compares whenever done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, rm;
        logic [63:0] ux, uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'd0: model = sx * sy;
            2'd1: model = ux * uy;
            default: begin
                if (y == 32'd0) begin
                    model = {x, 32'hFFFF_FFFF};
                end else if (o == 2'd2) begin
                    q = sx / sy;
                    rm = sx % sy;
                    model = {rm[31:0], q[31:0]};
                end else begin
                    model = {32'(ux % uy), 32'(ux / uy)};
                end
            end
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hi", {32'b0, hi}, {32'b0, mon_exp[63:32]});
                check("result_lo", {32'b0, lo}, {32'b0, mon_exp[31:0]});
            end
        end
    end

    // Launch one operation (caller is at a negedge) and wait for its done.
    // With disturb set, a stray start and an mthi are issued while busy.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit disturb);
        int lat;
        int busy_cnt;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (disturb) begin
                if (lat == 10) begin
                    start = 1'b1;
                    op = 2'($urandom);
                    a = $urandom;
                    b = $urandom;
                end
                if (lat == 11) start = 1'b0;
                if (lat == 12) begin
                    wr_hi = 1'b1;
                    wr_data = $urandom;
                end
                if (lat == 13) wr_hi = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(W + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        check("busy_in_done_cycle", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          saw_done;

        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'd3, 32'd100, 32'd0, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(2'd1, 32'd6, 32'd7, 1'b1);

        // mthi + mtlo together in IDLE.
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        check("mthi", {32'b0, hi}, 64'h0000_0000_DEAD_BEEF);
        check("mtlo", {32'b0, lo}, 64'h0000_0000_DEAD_BEEF);

        // Randomized back-to-back operations with boundary operands mixed in.
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'b0);
        end

        // Abort a divu 9/4 with reset about 20 cycles after launch.
        start = 1'b1;
        op = 2'd3;
        a = 32'd9;
        b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {63'b0, saw_done}, 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
